csr_trap_ctrl: RTL and testbench



---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_shadow.sv | 38 +++
 rtl/csr_trap_ctrl.sv | 159 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR constants and the trap sequencer state type used by csr_trap_ctrl
// and its shadow-register snooper.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;
   localparam int unsigned MIE_MEIE     = 11;

   localparam int unsigned CAUSE_MEI_CODE = 11;

   typedef enum logic [2:0] {
      IDLE,
      T_EPC,
      T_CAUSE,
      T_STATUS,
      T_JUMP,
      R_STATUS,
      R_JUMP
   } trap_state_e;

endpackage

// File: rtl/csr_shadow.sv
// Snoops the csr_regs write port and keeps local copies of the CSRs that trap
// decisions depend on, so the sequencer never spends a cycle reading them.
module csr_shadow
   import csr_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned ADDRW = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ADDRW-1:0] addr,
   input  logic             we,
   input  logic [DW-1:0]    wdata,
   output logic [DW-1:0]    mstatus,
   output logic             meie,
   output logic [DW-1:0]    mtvec,
   output logic [DW-1:0]    mepc
);

   // Only MEIE of mie influences trap entry, so that is the only bit kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus <= '0;
         meie    <= 1'b0;
         mtvec   <= '0;
         mepc    <= '0;
      end else if (we) begin
         case (addr)
            ADDRW'(CSR_MSTATUS): mstatus <= wdata;
            ADDRW'(CSR_MIE):     meie    <= wdata[MIE_MEIE];
            ADDRW'(CSR_MTVEC):   mtvec   <= wdata;
            ADDRW'(CSR_MEPC):    mepc    <= wdata;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Owns the csr_regs access port: passes pipeline accesses through when idle and
// sequences the CSR writes, flush and redirect for interrupt entry and mret.
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned ADDRW     = 12,
   parameter int unsigned CAUSE_MEI = CAUSE_MEI_CODE
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             intr_i,
   input  logic             mret_i,
   input  logic [DW-1:0]    pc_i,
   input  logic [ADDRW-1:0] pipe_addr_i,
   input  logic             pipe_we_i,
   input  logic             pipe_re_i,
   input  logic [DW-1:0]    pipe_wdata_i,
   output logic [DW-1:0]    pipe_rdata_o,
   output logic [ADDRW-1:0] csr_addr_o,
   output logic             csr_we_o,
   output logic             csr_re_o,
   output logic [DW-1:0]    csr_wdata_o,
   input  logic [DW-1:0]    csr_rdata_i,
   output logic             stall_o,
   output logic             flush_o,
   output logic             redirect_o,
   output logic [DW-1:0]    redirect_pc_o
);

   localparam logic [DW-1:0] CAUSE_VAL = {1'b1, (DW-1)'(CAUSE_MEI)};

   trap_state_e      state;
   logic             seq_we;
   logic [ADDRW-1:0] seq_addr;
   logic [DW-1:0]    seq_wdata;
   logic             stall;
   logic             flush;
   logic             redirect;
   logic [DW-1:0]    redirect_pc;

   logic [DW-1:0]    mstatus_sh;
   logic             meie_sh;
   logic [DW-1:0]    mtvec_sh;
   logic [DW-1:0]    mepc_sh;

   logic             idle;
   logic             pending;
   logic [DW-1:0]    status_trap;
   logic [DW-1:0]    status_ret;
   logic [DW-1:0]    vec_base;
   logic [DW-1:0]    trap_vec;

   csr_shadow #(
      .DW    (DW),
      .ADDRW (ADDRW)
   ) u_shadow (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .addr    (csr_addr_o),
      .we      (csr_we_o),
      .wdata   (csr_wdata_o),
      .mstatus (mstatus_sh),
      .meie    (meie_sh),
      .mtvec   (mtvec_sh),
      .mepc    (mepc_sh)
   );

   assign pending = intr_i & mstatus_sh[MSTATUS_MIE] & meie_sh;
   assign idle    = (state == IDLE);

   always_comb begin
      status_trap               = mstatus_sh;
      status_trap[MSTATUS_MPIE] = mstatus_sh[MSTATUS_MIE];
      status_trap[MSTATUS_MIE]  = 1'b0;
      status_ret                = mstatus_sh;
      status_ret[MSTATUS_MIE]   = mstatus_sh[MSTATUS_MPIE];
      status_ret[MSTATUS_MPIE]  = 1'b1;
      vec_base                  = {mtvec_sh[DW-1:2], 2'b00};
      trap_vec                  = (mtvec_sh[1:0] == 2'd1) ? vec_base + DW'(4 * CAUSE_MEI)
                                                          : vec_base;
   end

   // Outputs for the next cycle are registered alongside the state; the
   // captured trap PC (epc) travels in seq_wdata into the T_EPC write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         seq_we      <= 1'b0;
         seq_addr    <= '0;
         seq_wdata   <= '0;
         stall       <= 1'b0;
         flush       <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         seq_we   <= 1'b0;
         redirect <= 1'b0;
         stall    <= 1'b1;
         flush    <= 1'b1;
         case (state)
            IDLE: begin
               if (!pipe_we_i && mret_i) begin
                  state     <= R_STATUS;
                  seq_we    <= 1'b1;
                  seq_addr  <= ADDRW'(CSR_MSTATUS);
                  seq_wdata <= status_ret;
               end else if (!pipe_we_i && pending) begin
                  state     <= T_EPC;
                  seq_we    <= 1'b1;
                  seq_addr  <= ADDRW'(CSR_MEPC);
                  seq_wdata <= pc_i;
               end else begin
                  stall <= 1'b0;
                  flush <= 1'b0;
               end
            end
            T_EPC: begin
               state     <= T_CAUSE;
               seq_we    <= 1'b1;
               seq_addr  <= ADDRW'(CSR_MCAUSE);
               seq_wdata <= CAUSE_VAL;
            end
            T_CAUSE: begin
               state     <= T_STATUS;
               seq_we    <= 1'b1;
               seq_addr  <= ADDRW'(CSR_MSTATUS);
               seq_wdata <= status_trap;
            end
            T_STATUS: begin
               state       <= T_JUMP;
               redirect    <= 1'b1;
               redirect_pc <= trap_vec;
            end
            R_STATUS: begin
               state       <= R_JUMP;
               redirect    <= 1'b1;
               redirect_pc <= mepc_sh;
            end
            default: begin
               state <= IDLE;
               stall <= 1'b0;
               flush <= 1'b0;
            end
         endcase
      end
   end

   assign csr_addr_o    = idle ? pipe_addr_i : seq_addr;
   assign csr_wdata_o   = idle ? pipe_wdata_i : seq_wdata;
   assign csr_we_o      = rst_ni & (idle ? pipe_we_i : seq_we);
   assign csr_re_o      = rst_ni & idle & pipe_re_i;
   assign pipe_rdata_o  = (rst_ni & idle) ? csr_rdata_i : '0;
   assign stall_o       = stall;
   assign flush_o       = flush;
   assign redirect_o    = redirect;
   assign redirect_pc_o = redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed plus randomized check of csr_trap_ctrl against a transaction-level
// model of the trap/return rules, with a simple csr_regs array behind the port.
module tb_csr_trap_ctrl;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;

   typedef struct {
      bit          we;
      logic [11:0] addr;
      logic [31:0] data;
      bit          redir;
      logic [31:0] pc;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        intr, mret;
   logic [31:0] pc;
   logic [11:0] pipe_addr;
   logic        pipe_we, pipe_re;
   logic [31:0] pipe_wdata, pipe_rdata;
   logic [11:0] csr_addr;
   logic        csr_we, csr_re;
   logic [31:0] csr_wdata, csr_rdata;
   logic        stall, flush, redirect;
   logic [31:0] redirect_pc;

   logic [31:0] regs     [0:4095];
   logic [31:0] exp_regs [0:4095];
   logic [31:0] m_status, m_ie, m_tvec, m_epc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (csr_we) regs[csr_addr] <= csr_wdata;
   assign csr_rdata = regs[csr_addr];

   csr_trap_ctrl #(
      .DW        (32),
      .ADDRW     (12),
      .CAUSE_MEI (11)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .intr_i        (intr),
      .mret_i        (mret),
      .pc_i          (pc),
      .pipe_addr_i   (pipe_addr),
      .pipe_we_i     (pipe_we),
      .pipe_re_i     (pipe_re),
      .pipe_wdata_i  (pipe_wdata),
      .pipe_rdata_o  (pipe_rdata),
      .csr_addr_o    (csr_addr),
      .csr_we_o      (csr_we),
      .csr_re_o      (csr_re),
      .csr_wdata_o   (csr_wdata),
      .csr_rdata_i   (csr_rdata),
      .stall_o       (stall),
      .flush_o       (flush),
      .redirect_o    (redirect),
      .redirect_pc_o (redirect_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      exp_regs[a] = d;
      case (a)
         A_MSTATUS: m_status = d;
         A_MIE:     m_ie     = d;
         A_MTVEC:   m_tvec   = d;
         A_MEPC:    m_epc    = d;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] exp_vector();
      logic [31:0] base;
      base = m_tvec - (m_tvec % 4);
      return (m_tvec % 4 == 1) ? base + 4 * 11 : base;
   endfunction

   function automatic logic [31:0] exp_trap_status();
      return (m_status & ~32'h88) | (m_status[3] ? 32'h80 : 32'h0);
   endfunction

   function automatic logic [31:0] exp_ret_status();
      return (m_status & ~32'h08) | (m_status[7] ? 32'h08 : 32'h0) | 32'h80;
   endfunction

   task automatic clear_pipe();
      pipe_we = 1'b0; pipe_re = 1'b0; pipe_addr = '0; pipe_wdata = '0; mret = 1'b0;
   endtask

   // One idle-state cycle with the given inputs, followed by whatever sequence
   // the model predicts; pipe inputs are scrambled while the sequence runs.
   task automatic idle_cycle(input bit iv, input bit mv, input bit wv, input logic [11:0] a,
                             input logic [31:0] d, input logic [31:0] pcv, input string tag);
      step_t q[$];
      bit    pend;
      intr = iv; mret = mv; pipe_we = wv; pipe_re = 1'b0;
      pipe_addr = a; pipe_wdata = d; pc = pcv;
      pend = iv && m_status[3] && m_ie[11];
      @(negedge clk);
      chk({tag, ".we"}, 32'(csr_we), 32'(wv));
      if (wv) begin
         chk({tag, ".addr"}, 32'(csr_addr), 32'(a));
         chk({tag, ".wdata"}, csr_wdata, d);
      end
      chk({tag, ".stall"}, 32'(stall), 32'h0);
      chk({tag, ".redir"}, 32'(redirect), 32'h0);
      if (wv) begin
         model_write(a, d);
      end else if (mv) begin
         q.push_back('{1'b1, A_MSTATUS, exp_ret_status(), 1'b0, 32'h0});
         q.push_back('{1'b0, 12'h0, 32'h0, 1'b1, m_epc});
      end else if (pend) begin
         q.push_back('{1'b1, A_MEPC, pcv, 1'b0, 32'h0});
         q.push_back('{1'b1, A_MCAUSE, 32'h8000000B, 1'b0, 32'h0});
         q.push_back('{1'b1, A_MSTATUS, exp_trap_status(), 1'b0, 32'h0});
         q.push_back('{1'b0, 12'h0, 32'h0, 1'b1, exp_vector()});
      end
      @(posedge clk); #1;
      mret = 1'b0;
      foreach (q[i]) begin
         pipe_we    = 1'($urandom_range(0, 1));
         pipe_re    = 1'b1;
         pipe_addr  = A_MTVEC;
         pipe_wdata = $urandom;
         mret       = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk($sformatf("%s.s%0d.stall", tag, i), 32'(stall), 32'h1);
         chk($sformatf("%s.s%0d.flush", tag, i), 32'(flush), 32'h1);
         chk($sformatf("%s.s%0d.re", tag, i), 32'(csr_re), 32'h0);
         chk($sformatf("%s.s%0d.rdata", tag, i), pipe_rdata, 32'h0);
         chk($sformatf("%s.s%0d.we", tag, i), 32'(csr_we), 32'(q[i].we));
         if (q[i].we) begin
            chk($sformatf("%s.s%0d.addr", tag, i), 32'(csr_addr), 32'(q[i].addr));
            chk($sformatf("%s.s%0d.wdata", tag, i), csr_wdata, q[i].data);
            model_write(q[i].addr, q[i].data);
         end
         chk($sformatf("%s.s%0d.redir", tag, i), 32'(redirect), 32'(q[i].redir));
         if (q[i].redir) chk($sformatf("%s.s%0d.pc", tag, i), redirect_pc, q[i].pc);
         @(posedge clk); #1;
      end
      clear_pipe();
   endtask

   task automatic pipe_read(input logic [11:0] a, input string tag);
      intr = 1'b0; mret = 1'b0; pipe_we = 1'b0; pipe_re = 1'b1; pipe_addr = a;
      @(negedge clk);
      chk({tag, ".re"}, 32'(csr_re), 32'h1);
      chk({tag, ".rdata"}, pipe_rdata, exp_regs[a]);
      chk({tag, ".stall"}, 32'(stall), 32'h0);
      @(posedge clk); #1;
      clear_pipe();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".we"}, 32'(csr_we), 32'h0);
      chk({tag, ".re"}, 32'(csr_re), 32'h0);
      chk({tag, ".stall"}, 32'(stall), 32'h0);
      chk({tag, ".flush"}, 32'(flush), 32'h0);
      chk({tag, ".redir"}, 32'(redirect), 32'h0);
      chk({tag, ".pc"}, redirect_pc, 32'h0);
      chk({tag, ".rdata"}, pipe_rdata, 32'h0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
      idle_cycle(1'b0, 1'b0, 1'b1, a, d, 32'h0, tag);
   endtask

   initial begin
      logic [31:0] d;
      logic [11:0] a;
      int unsigned r;
      m_status = '0; m_ie = '0; m_tvec = '0; m_epc = '0;
      rst_n = 1'b0; intr = 1'b1; pc = 32'h0;
      pipe_we = 1'b1; pipe_re = 1'b1; pipe_addr = A_MSTATUS; pipe_wdata = 32'hFFFF_FFFF; mret = 1'b1;
      @(negedge clk);
      check_all_zero("rst");
      #12 rst_n = 1'b1;
      clear_pipe(); intr = 1'b0;
      @(posedge clk); #1;

      wr(A_MTVEC, 32'h100, "pt_w");
      pipe_read(A_MTVEC, "pt_r");

      wr(A_MSTATUS, 32'h8, "setup_ms");
      wr(A_MIE, 32'h800, "setup_mie");
      idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h40, "trap");
      idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h48, "no_retake");
      pipe_read(A_MSTATUS, "trap_ms");
      pipe_read(A_MEPC, "trap_epc");
      pipe_read(A_MCAUSE, "trap_cause");

      idle_cycle(1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 32'h48, "mret");
      pipe_read(A_MSTATUS, "mret_ms");

      intr = 1'b0;
      wr(A_MTVEC, 32'h101, "vec_tvec");
      idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h80, "vec");
      idle_cycle(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, "vec_mret");

      wr(A_MIE, 32'h0, "mask_mie");
      for (int i = 0; i < 3; i++) idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h90, "masked");

      wr(A_MIE, 32'h800, "coll_mie");
      idle_cycle(1'b1, 1'b0, 1'b1, A_MSTATUS, 32'h0, 32'hA0, "coll");
      idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'hA0, "coll_after");

      // reset while the sequencer is in T_CAUSE
      wr(A_MSTATUS, 32'h8, "rst_ms");
      intr = 1'b1; pc = 32'h44;
      @(posedge clk); #1;
      model_write(A_MEPC, 32'h44);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      pipe_we = 1'b1; pipe_re = 1'b1; pipe_addr = A_MSTATUS;
      #1 check_all_zero("midrst");
      #3 rst_n = 1'b1;
      m_status = '0; m_ie = '0; m_tvec = '0; m_epc = '0;
      clear_pipe(); intr = 1'b0;
      @(posedge clk); #1;
      idle_cycle(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h50, "post_rst");
      idle_cycle(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, "post_rst_mret");
      pipe_read(A_MEPC, "post_rst_epc");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: begin
               d = $urandom;
               d[3] = 1'($urandom_range(0, 1));
               wr(A_MSTATUS, d, "rnd_ms");
            end
            1: wr(A_MIE, ($urandom_range(0, 2) != 0) ? (32'h800 | ($urandom & 32'h888)) : $urandom, "rnd_mie");
            2: wr(($urandom_range(0, 1) != 0) ? A_MTVEC : A_MEPC, $urandom, "rnd_tv");
            3: begin
               case ($urandom_range(0, 3))
                  0: a = A_MSTATUS;
                  1: a = A_MTVEC;
                  2: a = A_MEPC;
                  default: a = A_MCAUSE;
               endcase
               pipe_read(a, "rnd_rd");
            end
            4: idle_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 12'h0, 32'h0, $urandom & ~32'h3, "rnd_mret");
            default: idle_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 12'h0, 32'h0,
                                $urandom & ~32'h3, "rnd_idle");
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
